// File: rtl/donut_frame_sequencer.sv
// Read-side sequencer for the animation ROM: walks frames, absorbs the ROM's
// one-cycle read latency in a 2-entry FIFO and streams pixels out valid/ready.
module donut_frame_sequencer #(
  parameter int unsigned FRAME_PIXELS = 281600,
  parameter int unsigned NUM_FRAMES   = 60,
  parameter int unsigned HOLD_FRAMES  = 1,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              play_i,
  input  logic              step_i,
  output logic              rom_cen_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [3:0]        rom_data_i,
  output logic [3:0]        pix_data_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic              pix_sof_o,
  output logic [5:0]        frame_idx_o,
  output logic              busy_o
);

  localparam int unsigned PIX_W  = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  localparam logic [PIX_W-1:0]  PIX_LAST     = PIX_W'(FRAME_PIXELS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [5:0]        FRAME_LAST   = 6'(NUM_FRAMES - 1);
  localparam logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(FRAME_PIXELS);

  logic [0:0]        state;
  logic              step_flag;
  logic [PIX_W-1:0]  pix_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [ADDR_W-1:0] frame_base;
  logic [5:0]        frame_idx;
  logic              inflight;
  logic              inflight_sof;

  logic [3:0] fifo_data [2];
  logic [1:0] fifo_sof;
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;

  logic       pop;
  logic       issue;
  logic       frame_end;
  logic [2:0] occupancy;

  assign pix_valid_o = (count != 2'd0);
  assign pop         = pix_valid_o & pix_ready_i;
  assign occupancy   = {1'b0, count} + {2'b0, inflight};
  // A pop this cycle frees a slot, so it may be reused by this cycle's issue.
  assign issue       = (state == STREAM) && (occupancy < (3'd2 + {2'b0, pop}));
  assign frame_end   = issue && (pix_idx == PIX_LAST);

  assign rom_cen_o   = issue;
  assign rom_addr_o  = frame_base + ADDR_W'(pix_idx);
  assign pix_data_o  = pix_valid_o ? fifo_data[rd_ptr] : 4'h0;
  assign pix_sof_o   = pix_valid_o & fifo_sof[rd_ptr];
  assign frame_idx_o = frame_idx;
  assign busy_o      = (state != IDLE) | inflight | pix_valid_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      step_flag    <= 1'b0;
      pix_idx      <= '0;
      hold_cnt     <= '0;
      frame_base   <= '0;
      frame_idx    <= '0;
      inflight     <= 1'b0;
      inflight_sof <= 1'b0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (play_i || step_i) begin
            state     <= STREAM;
            step_flag <= ~play_i;
          end
        end
        STREAM: begin
          if (frame_end) begin
            pix_idx <= '0;
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              if (frame_idx == FRAME_LAST) begin
                frame_idx  <= '0;
                frame_base <= '0;
              end else begin
                frame_idx  <= frame_idx + 6'd1;
                frame_base <= frame_base + FRAME_STRIDE;
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            if (step_flag || !play_i) begin
              step_flag <= 1'b0;
              state     <= IDLE;
            end
          end else if (issue) begin
            pix_idx <= pix_idx + PIX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      inflight     <= issue;
      inflight_sof <= issue && (pix_idx == '0);
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // Storage needs no reset: the head is masked until the count says it is valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && inflight) begin
      fifo_data[wr_ptr] <= rom_data_i;
      fifo_sof[wr_ptr]  <= inflight_sof;
    end
  end

endmodule

// File: doc/donut_frame_sequencer.md
# donut_frame_sequencer

Read-side controller for the animation ROM. It walks the 60-frame, 4-bit-per-pixel ROM frame by frame and drives the ROM's address and clock-enable. It absorbs the ROM's one-cycle read latency with a 2-entry output FIFO and presents pixels on a valid/ready stream to the display path. It also handles play/pause/single-step, per-frame hold (frame-rate division) and frame wrap-around.

## Interface
- FRAME_PIXELS, 281600, pixels per frame (640x440)
- NUM_FRAMES, 60, frames in ROM; frame index wraps NUM_FRAMES-1 -> 0
- HOLD_FRAMES, 1, number of times each frame is streamed before advancing (>=1)
- ADDR_W, 32, ROM address width
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- play_i  in  1  level; continuous playback while high
- step_i  in  1  pulse; in IDLE, stream exactly one frame then return to IDLE
- rom_cen_o  out  1  ROM clock enable; one read issued per cycle asserted
- rom_addr_o  out  ADDR_W  ROM read address
- rom_data_i  in  4  ROM registered read data, valid the cycle after a read issue
- pix_data_o  out  4  pixel value (FIFO head)
- pix_valid_o  out  1  FIFO non-empty
- pix_ready_i  in  1  consumer accepts; transfer when valid & ready
- pix_sof_o  out  1  head pixel is pixel 0 of a frame; qualified by pix_valid_o
- frame_idx_o  out  6  frame currently being issued
- busy_o  out  1  state != IDLE, or a read is in flight, or FIFO is non-empty

## Operation
- States: IDLE, STREAM.
- IDLE -> STREAM when play_i | step_i is sampled high; a latched step flag is set if play_i=0.
- In STREAM, a read is issued (rom_cen_o=1) in any cycle where (fifo_count + inflight - pop) < 2. Here pop = pix_valid_o & pix_ready_i.
- rom_addr_o = frame_base + pix_idx. frame_base is kept incrementally: +FRAME_PIXELS on advance, 0 on wrap. No multiplier. Maximum address is NUM_FRAMES*FRAME_PIXELS-1 = 16,895,999.
- Each issue increments pix_idx. When the issue is for pix_idx = FRAME_PIXELS-1 (the frame-end issue):
  - pix_idx -> 0 and hold_cnt increments.
  - If hold_cnt = HOLD_FRAMES-1: hold_cnt -> 0 and frame_idx advances. NUM_FRAMES-1 wraps to 0 together with frame_base.
  - If the step flag is set, or play_i=0 in that cycle: clear the step flag and go to IDLE. Otherwise stay in STREAM.
- play_i is ignored mid-frame. Pausing takes effect only at frame boundaries. step_i is ignored outside IDLE.
- An inflight flag is set on issue. rom_data_i is written to the FIFO the next cycle and inflight is cleared. A sof tag (pix_idx==0 at issue) travels with the data.
- The FIFO drains independently of state. IDLE with a non-empty FIFO keeps pix_valid_o asserted.
- rom_cen_o=0 whenever no read is issued. The ROM holds its output then, and that value is never captured.

## Timing
- Reset values: state IDLE; rom_cen_o=0; rom_addr_o=0; pix_valid_o=0; pix_sof_o=0; pix_data_o=0; frame_idx_o=0; busy_o=0; FIFO empty; inflight=0; hold_cnt=0; pix_idx=0; frame_base=0.
- play_i sampled in IDLE at cycle N:
  - STREAM with rom_cen_o=1, rom_addr_o=frame_base at N+1.
  - Data captured at end of N+2.
  - pix_valid_o=1 at N+3 (3-cycle latency).
- Steady state with pix_ready_i=1: one pixel per cycle, no bubbles, including across frame and wrap boundaries.
- The FIFO never overflows, and reads never exceed 2 outstanding (FIFO + in flight).
- Simultaneous push and pop with the FIFO full (count 2): legal, count stays 2.
- pix_ready_i=0 with the FIFO full: no issue, addresses held, no data lost.
- Reset mid-operation, effective the next edge: all state returns to reset values. Any in-flight ROM data is discarded: rom_data_i in the cycle after reset is not captured.
- frame_idx_o updates the cycle after the frame-end issue. busy_o drops the cycle after the last FIFO pop in IDLE.

## Test plan
- Reset: hold rst_i 3 cycles with play_i=1 -> all outputs at reset values. First rom_cen_o on the 1st cycle after rst_i falls; first pix_valid_o 3 cycles after the first sampled play_i.
- Free-run, pix_ready_i=1, FRAME_PIXELS=16, NUM_FRAMES=3, HOLD_FRAMES=1:
  - Addresses 0..47 then 0.
  - Pixel stream equals the ROM contents in order.
  - pix_sof_o on addresses 0, 16, 32.
  - frame_idx_o sequence 0,1,2,0.
- Hold: HOLD_FRAMES=2, same sizes -> address blocks 0-15, 0-15, 16-31, 16-31, 32-47, 32-47, 0-15.
- Backpressure: random pix_ready_i at 30% duty over 5 frames:
  - Output sequence identical to the free-run case.
  - Never more than 2 outstanding reads.
  - No duplicated or dropped pixel.
- Pause/step:
  - Drop play_i at pixel 5 -> frame completes to pixel 15, state goes to IDLE, busy_o falls after the drain; frame_idx_o=1.
  - One step_i pulse -> exactly 16 pixels (addresses 16-31), then IDLE.
- Mid-stream reset:
  - Assert rst_i with the FIFO full and a read in flight -> next cycle pix_valid_o=0; no stale pixel ever appears.
  - Replay restarts at address 0 with pix_sof_o=1.
